// File: rtl/fnd_scan_decoder.sv
// Reads a multiplexed 4-digit FND scan back into BCD and binary.
// Optional per-digit decimal point capture: define FND_DP_CAPTURE_EN.
module fnd_scan_decoder #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  fnd_digit,
   input  logic [7:0]  fnd_data,
   output logic [15:0] bcd,
   output logic [13:0] value,
   output logic        frame_valid,
   output logic        seg_err
`ifdef FND_DP_CAPTURE_EN
   ,
   output logic [3:0]  dp
`endif
);

   localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
`ifdef FND_DP_CAPTURE_EN
   localparam logic [7:0] CMP_MASK = 8'hFF;
`else
   localparam logic [7:0] CMP_MASK = 8'h7F;
`endif

   typedef enum logic [1:0] {
      S_COLLECT,
      S_CONV,
      S_OUT
   } state_t;

   state_t state, state_nx;

   logic [3:0]    prev_digit;
   logic [7:0]    prev_data;
   logic [CW-1:0] cnt;
   logic [15:0]   slots;
   logic [3:0]    mask, mask_nx;
   logic          err, err_nx;
   logic [15:0]   snap;
   logic          snap_err;
   logic [13:0]   acc, acc_nx;
   logic [1:0]    idx;

   logic          sel_ok;
   logic [1:0]    sel_idx;
   logic [3:0]    seg_bcd;
   logic          seg_bad;
   logic          stable, cap;
   logic          snap_en, conv_en, out_en;

`ifdef FND_DP_CAPTURE_EN
   logic [3:0] dp_slot, snap_dp;
`endif

   always_comb begin
      sel_ok  = 1'b1;
      sel_idx = 2'd0;
      case (fnd_digit)
         4'b1110: sel_idx = 2'd0;
         4'b1101: sel_idx = 2'd1;
         4'b1011: sel_idx = 2'd2;
         4'b0111: sel_idx = 2'd3;
         default: sel_ok  = 1'b0;
      endcase
   end

   // dp (bit7) never takes part in the digit decode
   always_comb begin
      seg_bcd = 4'd0;
      seg_bad = 1'b0;
      case (fnd_data[6:0])
         7'h40:   seg_bcd = 4'd0;
         7'h79:   seg_bcd = 4'd1;
         7'h24:   seg_bcd = 4'd2;
         7'h30:   seg_bcd = 4'd3;
         7'h19:   seg_bcd = 4'd4;
         7'h12:   seg_bcd = 4'd5;
         7'h02:   seg_bcd = 4'd6;
         7'h78:   seg_bcd = 4'd7;
         7'h00:   seg_bcd = 4'd8;
         7'h10:   seg_bcd = 4'd9;
         default: seg_bad = 1'b1;
      endcase
   end

   assign stable = sel_ok
                && (fnd_digit == prev_digit)
                && ((fnd_data & CMP_MASK) == (prev_data & CMP_MASK));
   assign cap    = stable && (cnt == CNT_MAX - 1'b1);

   always_comb begin
      mask_nx = snap_en ? 4'd0 : mask;
      err_nx  = snap_en ? 1'b0 : err;
      if (cap) begin
         mask_nx[sel_idx] = 1'b1;
         err_nx           = err_nx | seg_bad;
      end
   end

   assign acc_nx = (acc << 3) + (acc << 1)
                 + {10'd0, snap[{idx, 2'b00} +: 4]};

   always_ff @(posedge clk) begin
      if (!reset) state <= S_COLLECT;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      snap_en  = 1'b0;
      conv_en  = 1'b0;
      out_en   = 1'b0;
      case (state)
         S_COLLECT: begin
            if (mask == 4'hF) begin
               snap_en  = 1'b1;
               state_nx = S_CONV;
            end
         end
         S_CONV: begin
            conv_en = 1'b1;
            if (idx == 2'd0) begin
               out_en   = 1'b1;
               state_nx = S_OUT;
            end
         end
         S_OUT:   state_nx = S_COLLECT;
         default: state_nx = S_COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         prev_digit  <= 4'hF;
         prev_data   <= 8'hFF;
         cnt         <= '0;
         slots       <= 16'd0;
         mask        <= 4'd0;
         err         <= 1'b0;
         snap        <= 16'd0;
         snap_err    <= 1'b0;
         acc         <= 14'd0;
         idx         <= 2'd0;
         bcd         <= 16'd0;
         value       <= 14'd0;
         frame_valid <= 1'b0;
         seg_err     <= 1'b0;
      end else begin
         prev_digit  <= fnd_digit;
         prev_data   <= fnd_data;
         if (!stable)              cnt <= '0;
         else if (cnt != CNT_MAX)  cnt <= cnt + 1'b1;
         mask        <= mask_nx;
         err         <= err_nx;
         if (cap) slots[{sel_idx, 2'b00} +: 4] <= seg_bcd;
         if (snap_en) begin
            snap     <= slots;
            snap_err <= err;
            acc      <= 14'd0;
            idx      <= 2'd3;
         end
         if (conv_en) begin
            acc <= acc_nx;
            idx <= idx - 2'd1;
         end
         frame_valid <= out_en;
         if (out_en) begin
            value   <= acc_nx;
            bcd     <= snap;
            seg_err <= snap_err;
         end
      end
   end

`ifdef FND_DP_CAPTURE_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         dp_slot <= 4'd0;
         snap_dp <= 4'd0;
         dp      <= 4'd0;
      end else begin
         if (cap)     dp_slot[sel_idx] <= ~fnd_data[7];
         if (snap_en) snap_dp <= dp_slot;
         if (out_en)  dp <= snap_dp;
      end
   end
`endif

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Directed bench for fnd_scan_decoder: scans frames and checks decode,
// latency, stability filtering, segment errors and reset abort.
module tb_fnd_scan_decoder;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  fnd_digit;
   logic [7:0]  fnd_data;
   logic [15:0] bcd;
   logic [13:0] value;
   logic        frame_valid;
   logic        seg_err;
`ifdef FND_DP_CAPTURE_EN
   logic [3:0]  dp;
`endif

   int checks = 0;
   int passed = 0;
   int fv_cnt = 0;
   int base;
   logic [15:0] lat_bcd;
   logic [13:0] lat_val;
   logic        lat_err;

   fnd_scan_decoder #(.STABLE_CYCLES(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .fnd_digit   (fnd_digit),
      .fnd_data    (fnd_data),
      .bcd         (bcd),
      .value       (value),
      .frame_valid (frame_valid),
      .seg_err     (seg_err)
`ifdef FND_DP_CAPTURE_EN
      ,
      .dp          (dp)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_valid) begin
         fv_cnt++;
         lat_bcd = bcd;
         lat_val = value;
         lat_err = seg_err;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step(input logic [3:0] dg, input logic [7:0] dt,
                       input int n);
      fnd_digit = dg;
      fnd_data  = dt;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // codes given ones..thousands; last digit gets its own dwell
   task automatic scan(input logic [7:0] c0, input logic [7:0] c1,
                       input logic [7:0] c2, input logic [7:0] c3,
                       input int dw, input int dw_last);
      step(4'b1110, c0, dw);
      step(4'b1101, c1, dw);
      step(4'b1011, c2, dw);
      step(4'b0111, c3, dw_last);
   endtask

   initial begin
      reset     = 1'b0;
      fnd_digit = 4'hF;
      fnd_data  = 8'hFF;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_value", 32'(value), 32'd0);
      chk("rst_bcd", 32'(bcd), 32'd0);
      chk("rst_seg_err", 32'(seg_err), 32'd0);
      chk("rst_fv", 32'(frame_valid), 32'd0);
      reset = 1'b1;
      step(4'hF, 8'hFF, 2);

      // 0510 with exact latency check
      base = fv_cnt;
      scan(8'hC0, 8'hF9, 8'h92, 8'hC0, 8, 4);
      step(4'hF, 8'hFF, 4);
      chk("t1_fv_early", 32'(frame_valid), 32'd0);
      step(4'hF, 8'hFF, 1);
      chk("t1_fv", 32'(frame_valid), 32'd1);
      chk("t1_value", 32'(value), 32'd510);
      chk("t1_bcd", 32'(bcd), 32'h0510);
      chk("t1_seg_err", 32'(seg_err), 32'd0);
      step(4'hF, 8'hFF, 1);
      chk("t1_fv_pulse", 32'(frame_valid), 32'd0);
      step(4'hF, 8'hFF, 8);
      chk("t1_fv_count", 32'(fv_cnt - base), 32'd1);

      // 3-clock dwell never captures; 4-clock dwell does
      base = fv_cnt;
      scan(8'h82, 8'hF8, 8'h80, 8'h90, 3, 3);
      step(4'hF, 8'hFF, 12);
      chk("t2_short_none", 32'(fv_cnt - base), 32'd0);
      scan(8'h82, 8'hF8, 8'h80, 8'h90, 4, 4);
      step(4'hF, 8'hFF, 12);
      chk("t2_count", 32'(fv_cnt - base), 32'd1);
      chk("t2_value", 32'(lat_val), 32'd9876);
      chk("t2_bcd", 32'(lat_bcd), 32'h9876);

      // invalid tens code, then a clean frame
      base = fv_cnt;
      scan(8'h99, 8'hFF, 8'hA4, 8'hF9, 8, 8);
      step(4'hF, 8'hFF, 12);
      chk("t3_err_count", 32'(fv_cnt - base), 32'd1);
      chk("t3_err_flag", 32'(lat_err), 32'd1);
      chk("t3_err_bcd", 32'(lat_bcd), 32'h1204);
      chk("t3_err_value", 32'(lat_val), 32'd1204);
      chk("t3_err_held", 32'(seg_err), 32'd1);
      scan(8'h99, 8'hB0, 8'hA4, 8'hF9, 8, 8);
      step(4'hF, 8'hFF, 12);
      chk("t3_clean_flag", 32'(lat_err), 32'd0);
      chk("t3_clean_value", 32'(lat_val), 32'd1234);
      chk("t3_clean_bcd", 32'(lat_bcd), 32'h1234);

      // multi-select and blank gaps between digits
      base = fv_cnt;
      step(4'b1110, 8'h90, 8);
      step(4'b1100, 8'h90, 6);
      step(4'b1111, 8'h90, 6);
      step(4'b1101, 8'h90, 8);
      step(4'b1100, 8'hFF, 6);
      step(4'b1011, 8'h90, 8);
      step(4'b1111, 8'h7F, 6);
      step(4'b0111, 8'h90, 8);
      step(4'hF, 8'hFF, 12);
      chk("t4_count", 32'(fv_cnt - base), 32'd1);
      chk("t4_value", 32'(lat_val), 32'd9999);
      chk("t4_bcd", 32'(lat_bcd), 32'h9999);
      chk("t4_seg_err", 32'(lat_err), 32'd0);

      // reset during conversion aborts the frame
      base = fv_cnt;
      scan(8'h99, 8'hB0, 8'hA4, 8'hF9, 8, 4);
      step(4'hF, 8'hFF, 2);
      reset = 1'b0;
      step(4'hF, 8'hFF, 2);
      reset = 1'b1;
      step(4'hF, 8'hFF, 10);
      chk("t5_abort_none", 32'(fv_cnt - base), 32'd0);
      chk("t5_abort_value", 32'(value), 32'd0);
      chk("t5_abort_bcd", 32'(bcd), 32'd0);
      scan(8'hA4, 8'h99, 8'hC0, 8'hC0, 8, 8);
      step(4'hF, 8'hFF, 12);
      chk("t5_count", 32'(fv_cnt - base), 32'd1);
      chk("t5_value", 32'(lat_val), 32'd42);
      chk("t5_bcd", 32'(lat_bcd), 32'h0042);

      // dp lit on hundreds only
      base = fv_cnt;
      scan(8'hC0, 8'hF9, 8'h12, 8'hC0, 8, 4);
      step(4'hF, 8'hFF, 5);
      chk("t6_fv", 32'(frame_valid), 32'd1);
      chk("t6_value", 32'(value), 32'd510);
`ifdef FND_DP_CAPTURE_EN
      chk("t6_dp", 32'(dp), 32'h4);
`endif
      step(4'hF, 8'hFF, 8);
      chk("t6_count", 32'(fv_cnt - base), 32'd1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/fnd_scan_decoder.md
Name: fnd_scan_decoder

Overview:
- Receive-side counterpart of the 4-digit FND scan controller.
- Watches the multiplexed fnd_digit/fnd_data scan lines, captures each digit once its select and segment code are stable, and decodes the 7-segment pattern back to BCD.
- After all four digits are captured, converts the 4-digit BCD frame to binary and emits a one-cycle frame_valid pulse.
- Used as a scan readback/self-check block beside the adder display path, e.g. expects 510 for 8'hFF+8'hFF.

Parameters:
STABLE_CYCLES, 4, consecutive clocks a digit select and segment code must hold unchanged before capture (minimum 2).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
fnd_digit  input  4  active-low digit select; bit0 = ones, bit1 = tens, bit2 = hundreds, bit3 = thousands
fnd_data  input  8  active-low segments {dp,g,f,e,d,c,b,a}
bcd  output  16  last completed frame {thousands,hundreds,tens,ones}
value  output  14  binary value of last completed frame, 0..9999
frame_valid  output  1  one-cycle pulse when bcd/value update
seg_err  output  1  set with frame_valid if any digit in that frame had an invalid segment code; held until next frame

Behaviour:
- Reset (reset==0 at posedge): all outputs are 0, capture mask is cleared, stability counter is 0, FSM goes to S_COLLECT.
- Segment decode ignores dp (bit7), using bits [6:0]:
  - 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7, 0x00→8, 0x10→9.
  - Any other code decodes to 0 and sets the per-frame error flag.
- Valid select is exactly one 0 bit in fnd_digit.
  - All-ones is a blanking gap: counter resets, no capture.
  - Multiple zeros: counter resets, no capture, no error.
- Stability:
  - The counter increments while fnd_digit and fnd_data equal their previous-cycle values and the select is valid; otherwise it resets to 0.
  - When the counter reaches STABLE_CYCLES-1, the digit is captured into its BCD slot and its mask bit is set.
  - Exactly one capture per dwell; the counter saturates until the inputs change.
  - Re-capturing an already-masked digit overwrites its slot; the mask is unchanged.
- S_COLLECT:
  - When the mask becomes 4'hF (including on the capturing edge), the next cycle snapshots the 4 slots plus the error flag, clears mask and error flag, and enters S_CONV.
- S_CONV, 4 cycles, thousands first:
  - acc = acc*10 + digit, starting from acc=0.
  - acc*10 is computed as (acc<<3)+(acc<<1); 14-bit width is sufficient, max 9999.
- S_OUT, 1 cycle:
  - value<=acc, bcd<=snapshot, seg_err<=snapshot error, frame_valid=1.
  - Returns to S_COLLECT.
- Latency: frame_valid is high in the 6th cycle after the edge that captured the 4th digit (1 snapshot + 4 convert + 1 out).
- Capturing continues during S_CONV/S_OUT into the cleared mask.
  - A mask that completes while not in S_COLLECT is acted on once the FSM returns to S_COLLECT.
- Reset asserted mid-conversion aborts it: no frame_valid, outputs return to 0.

Optional Feature:
FND_DP_CAPTURE_EN
- Defined: adds output dp (4 bits, active-high per digit).
  - Captured from ~fnd_data[7] alongside each digit.
  - Updated with frame_valid; reset 0.
- Undefined: port is absent and fnd_data[7] is ignored.

Test Plan:
1. Scan ones..thousands codes {0x40,0x79,0x12,0x40} with 0xC0 dp-off (i.e. 0xC0,0xF9,0x92,0xC0), 8 clocks per digit → frame_valid once; bcd=16'h0510, value=510, seg_err=0.
2. Digit dwell of 3 clocks with STABLE_CYCLES=4 → no captures, frame_valid never asserts; then extend dwell to 4 → frame completes.
3. Tens code 0x7F (blank) in one frame → frame_valid with seg_err=1, tens=0; next clean frame of 1234 → seg_err=0, value=1234.
4. fnd_digit=4'b1100 and 4'b1111 between digits → no capture, no error; a clean frame still decodes 9999 → value=9999.
5. Assert reset during S_CONV → no frame_valid, value=0; a subsequent full scan of 0042 → value=42.
6. With FND_DP_CAPTURE_EN, dp lit on hundreds (0x12 code) → dp=4'b0100 at frame_valid.
